// File: rtl/bonus_manager.sv
// Falling bonus item manager: spawns one item per slot, moves it once per frame,
// hit-tests it against the plane, and keeps the bomb stock and timed-effect timers.
module bonus_manager #(
    parameter  int NUM_TYPES     = 2,
    parameter  int RAND_W        = 16,
    parameter  int H_W           = 10,
    parameter  int V_W           = 10,
    parameter  int H_DISP        = 640,
    parameter  int V_DISP        = 480,
    parameter  int SIZE          = 32,
    parameter  int FALL_STEP     = 2,
    parameter  int SPAWN_FRAMES  = 300,
    parameter  int EFFECT_FRAMES = 600,
    parameter  int BOMB_MAX      = 3,
    localparam int TW            = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1,
    localparam int CW            = $clog2(BOMB_MAX + 1)
) (
    input  logic                 clk_run,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic [RAND_W-1:0]    rand_i,
    input  logic                 v_sync_i,
    input  logic [H_W-1:0]       req_x_addr_i,
    input  logic [V_W-1:0]       req_y_addr_i,
    input  logic                 crash_i,
    input  logic                 bomb_use_i,
    output logic                 alpha_o,
    output logic [TW-1:0]        type_o,
    output logic [NUM_TYPES-1:0] pickup_o,
    output logic [NUM_TYPES-1:0] effect_o,
    output logic [CW-1:0]        bomb_cnt_o,
    output logic                 bomb_fire_o
);

    localparam int SCW  = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam int EW   = $clog2(EFFECT_FRAMES + 1);
    localparam int XMAX = H_DISP - SIZE;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FALL = 1'b1;

    logic [0:0]     state;
    logic [H_W-1:0] x_q;
    logic [V_W-1:0] y_q;
    logic [TW-1:0]  type_q;
    logic [SCW-1:0] spawn_cnt;
    logic           v_prev;

    logic           step;
    logic [TW-1:0]  spawn_t;
    logic [H_W-1:0] spawn_xr;
    logic [H_W-1:0] spawn_x;
    logic           spawn_ok;
    logic [V_W:0]   y_next;
    logic           at_bottom;
    logic [H_W:0]   x_end;
    logic [V_W:0]   y_end;
    logic           in_x;
    logic           in_y;
    logic           collect;
    logic           bomb_collect;
    logic           use_ok;
    logic           unused_rand;

    assign step      = v_sync_i & ~v_prev & en_i;
    assign spawn_t   = rand_i[RAND_W-1 -: TW];
    assign spawn_xr  = rand_i[H_W-1:0];
    assign spawn_ok  = {1'b0, spawn_t} < (TW+1)'(NUM_TYPES);
    assign spawn_x   = (spawn_xr >= H_W'(XMAX)) ? spawn_xr - H_W'(XMAX) : spawn_xr;
    assign y_next    = {1'b0, y_q} + (V_W+1)'(FALL_STEP);
    assign at_bottom = y_next >= (V_W+1)'(V_DISP);
    assign unused_rand = ^rand_i;

    // Extents are one bit wider so an item touching the right/bottom edge never wraps.
    assign x_end   = {1'b0, x_q} + (H_W+1)'(SIZE);
    assign y_end   = {1'b0, y_q} + (V_W+1)'(SIZE);
    assign in_x    = (req_x_addr_i >= x_q) && ({1'b0, req_x_addr_i} < x_end);
    assign in_y    = (req_y_addr_i >= y_q) && ({1'b0, req_y_addr_i} < y_end);
    assign alpha_o = (state == FALL) && in_x && in_y;
    assign type_o  = type_q;

    assign collect      = crash_i & alpha_o;
    assign bomb_collect = collect && (type_q == '0);
    assign use_ok       = bomb_use_i && (bomb_cnt_o != '0);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_run or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            type_q    <= '0;
            spawn_cnt <= '0;
            v_prev    <= 1'b0;
        end else begin
            v_prev <= v_sync_i;
            if (state == IDLE) begin
                if (step) begin
                    if (spawn_cnt == SCW'(SPAWN_FRAMES - 1)) begin
                        if (spawn_ok) begin
                            spawn_cnt <= '0;
                            type_q    <= spawn_t;
                            x_q       <= spawn_x;
                            y_q       <= '0;
                            state     <= FALL;
                        end
                    end else begin
                        spawn_cnt <= spawn_cnt + SCW'(1);
                    end
                end
            end else if (collect) begin
                state <= IDLE;
            end else if (step) begin
                if (at_bottom) state <= IDLE;
                else           y_q   <= y_next[V_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_run or negedge rst) begin
        if (!rst) begin
            pickup_o    <= '0;
            bomb_cnt_o  <= '0;
            bomb_fire_o <= 1'b0;
        end else begin
            pickup_o    <= collect ? (NUM_TYPES'(1) << type_q) : '0;
            bomb_fire_o <= use_ok;
            // Collect plus use in one cycle leaves the stock unchanged, even at saturation.
            case ({bomb_collect, use_ok})
                2'b10:   if (bomb_cnt_o != CW'(BOMB_MAX)) bomb_cnt_o <= bomb_cnt_o + CW'(1);
                2'b01:   bomb_cnt_o <= bomb_cnt_o - CW'(1);
                default: bomb_cnt_o <= bomb_cnt_o;
            endcase
        end
    end

    assign effect_o[0] = 1'b0;

    for (genvar k = 1; k < NUM_TYPES; k++) begin : g_timer
        logic [EW-1:0] timer;

        always_ff @(posedge clk_run or negedge rst) begin
            if (!rst) begin
                timer <= '0;
            end else if (collect && (type_q == TW'(k))) begin
                timer <= EW'(EFFECT_FRAMES);
            end else if (step && (timer != '0)) begin
                timer <= timer - EW'(1);
            end
        end

        assign effect_o[k] = (timer != '0);
    end

endmodule
